// File: rtl/rr_grant_arbiter8.sv
// Round-robin owner arbiter for an 8-way one-hot select; grant/index/valid/timeout all registered, 1-cycle request-to-grant.
// No backpressure: owner keeps the grant until done, request drop or MAX_HOLD cycles, then hands over on the same edge.
module rr_grant_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [7:0]         r_grant;
    logic [2:0]         r_idx;
    logic [2:0]         r_ptr;
    logic [CNT_W-1:0]   r_hold;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic [7:0]         w_grant_nxt;
    logic [2:0]         w_idx_nxt;
    logic [2:0]         w_ptr_nxt;
    logic [CNT_W-1:0]   w_hold_nxt;
    logic               w_timeout_nxt;

    logic               w_own_req;
    logic               w_own_done;
    logic               w_hold_hit;
    logic               w_release;
    logic [2:0]         w_arb_ptr;
    logic [7:0]         w_arb_req;
    logic               w_win_vld;
    logic [2:0]         w_win_idx;

    // First set bit of m scanning p, p+1, ... p+7 (mod 8); MSB flags a hit.
    function automatic logic [3:0] pick_first(input logic [7:0] m, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (m[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_own_req  = req[r_idx];
    assign w_own_done = done[r_idx];
    assign w_hold_hit = (r_hold == CNT_W'(MAX_HOLD));
    assign w_release  = w_own_done | ~w_own_req | w_hold_hit;

    // On handover the current owner is masked out so it cannot immediately re-win.
    assign w_arb_ptr = (r_state == S_IDLE) ? r_ptr : (r_idx + 3'd1);
    assign w_arb_req = (r_state == S_IDLE) ? req : (req & ~(8'b1 << r_idx));
    assign {w_win_vld, w_win_idx} = pick_first(w_arb_req, w_arb_ptr);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = 8'b1 << w_win_idx;
                    w_idx_nxt   = w_win_idx;
                    w_hold_nxt  = CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (!w_release) begin
                    w_hold_nxt = r_hold + CNT_W'(1);
                end else begin
                    w_ptr_nxt     = r_idx + 3'd1;
                    w_timeout_nxt = w_hold_hit & ~w_own_done & w_own_req;
                    if (w_win_vld) begin
                        w_grant_nxt = 8'b1 << w_win_idx;
                        w_idx_nxt   = w_win_idx;
                        w_hold_nxt  = CNT_W'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = 8'h00;
                        w_idx_nxt   = 3'd0;
                        w_hold_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 8'h00;
                w_idx_nxt   = 3'd0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= 8'h00;
            r_idx     <= 3'd0;
            r_ptr     <= 3'd0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = (r_state == S_BUSY);
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Scoreboarded bench for rr_grant_arbiter8: directed scenarios then random traffic against an owner/pointer model.
module tb_rr_grant_arbiter8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] done = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    rr_grant_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: owner is -1 when idle; ptr is the requester with top priority.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic int search(input logic [7:0] r, input int start, input int span);
        for (int k = 0; k < span; k++)
            if (r[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    task automatic model_step(input bit rs, input logic [7:0] r, input logic [7:0] d);
        bit rel;
        m_to = 0;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            m_owner = search(r, m_ptr, 8);
            m_hold  = (m_owner < 0) ? 0 : 1;
        end else begin
            rel  = d[m_owner] || !r[m_owner] || (m_hold == MAX_HOLD);
            m_to = !d[m_owner] && r[m_owner] && (m_hold == MAX_HOLD);
            if (!rel) begin
                m_hold++;
            end else begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = search(r, m_ptr, 7);  // span 7 skips the old owner
                m_hold  = (m_owner < 0) ? 0 : 1;
            end
        end
    endtask

    task automatic drive(input bit rs, input logic [7:0] r, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst = rs; req = r; done = d;
        model_step(rs, r, d);
        e.v = (m_owner >= 0);
        e.g = e.v ? (8'b1 << m_owner) : 8'h00;
        e.i = e.v ? 3'(m_owner) : 3'd0;
        e.t = m_to;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] owner_bit();
        return (m_owner < 0) ? 8'h00 : (8'b1 << m_owner);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",       32'(grant),       32'(e.g));
                chk("grant_idx",   32'(grant_idx),   32'(e.i));
                chk("grant_valid", 32'(grant_valid), 32'(e.v));
                chk("timeout",     32'(timeout),     32'(e.t));
            end
        end
    end

    initial begin : stim
        logic [7:0] r;
        logic [7:0] d;
        // Reset then single request and release
        drive(1, 8'h00, 8'h00);
        drive(1, 8'h00, 8'h00);
        drive(0, 8'h04, 8'h00);
        drive(0, 8'h04, 8'h00);
        drive(0, 8'h04, 8'h04);
        drive(0, 8'h00, 8'h00);
        // Fairness with wrap
        drive(1, 8'h00, 8'h00);
        for (int n = 0; n < 10; n++) begin
            drive(0, 8'hFF, 8'h00);
            drive(0, 8'hFF, owner_bit());
        end
        // Pointer priority after owner 5 releases
        drive(1, 8'h00, 8'h00);
        drive(0, 8'h20, 8'h00);
        drive(0, 8'h20, 8'h20);
        drive(0, 8'h21, 8'h00);
        drive(0, 8'h21, 8'h00);
        // Hold timeout and handover
        drive(1, 8'h00, 8'h00);
        for (int n = 0; n < 14; n++) drive(0, 8'h09, 8'h00);
        // Timeout coinciding with done
        drive(1, 8'h00, 8'h00);
        for (int n = 0; n < 4; n++) drive(0, 8'h03, 8'h00);
        drive(0, 8'h03, owner_bit());
        drive(0, 8'h03, 8'h00);
        // Request drop
        drive(1, 8'h00, 8'h00);
        drive(0, 8'h08, 8'h00);
        drive(0, 8'h88, 8'h00);
        drive(0, 8'h80, 8'h00);
        drive(0, 8'h00, 8'h00);
        drive(0, 8'h08, 8'h00);
        drive(0, 8'h00, 8'h00);
        drive(0, 8'h00, 8'hFF);
        // Reset mid-grant
        drive(0, 8'h10, 8'h00);
        drive(0, 8'h10, 8'h00);
        drive(1, 8'h10, 8'h00);
        drive(0, 8'h11, 8'h00);
        drive(0, 8'h11, 8'h00);
        // Random traffic with sticky requests
        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            d = 8'h00;
            if ($urandom_range(3) == 0) d = owner_bit();
            if ($urandom_range(5) == 0) d = d | 8'($urandom);
            drive($urandom_range(299) == 0, r, d);
        end
        drive(0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way one-hot select resource between 8 requesters.
- Registers a one-hot grant vector plus its 3-bit encoded index, so downstream 3-to-8 decode and select logic sees a stable, glitch-free select.
- Holds each grant until the owner releases it, drops its request, or exceeds a hold-time limit.
- Sits between requesting engines and the shared output select.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may own the grant; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request per requester; bit i = requester i
- done  input  8  per-requester release pulse; only the bit of the current owner is honoured
- grant  output  8  registered one-hot grant; all zero when idle
- grant_idx  output  3  registered binary index of the owner; 3'd0 when idle
- grant_valid  output  1  registered; 1 while any grant is active
- timeout  output  1  registered one-cycle pulse when the hold limit forces a release

Behaviour:
- Reset (rst=1 at a clk edge): grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE. Reset asserted mid-grant drops the grant on that same edge.
- ptr is the highest-priority index. Priority order is ptr, ptr+1, ..., ptr+7, all modulo 8 (wraps 7 to 0).
- Winner is the first index in priority order with req set. It is computed combinationally from req and the arbitration pointer.
- States:
  - IDLE: grant_valid=0. If req!=0, then next edge: state=BUSY, grant=onehot(winner), grant_idx=winner, hold_cnt=1. Request-to-grant latency is 1 cycle.
  - BUSY: owner o=grant_idx. Release condition R = done[o] | ~req[o] | (hold_cnt==MAX_HOLD).
    - R=0: grant holds; hold_cnt increments.
    - R=1: ptr <= o+1 (mod 8). Winner is recomputed using o+1 as the pointer and excluding o.
      - If another request exists: the grant moves to that winner on the same edge (back-to-back, no idle bubble) and hold_cnt=1.
      - Otherwise: state=IDLE and grant clears.
- Owner excluded on release: a requester that still has req high after done or timeout cannot win the immediately following arbitration. It is eligible again from the cycle after.
- timeout=1 for exactly one cycle after the edge where the release was caused only by hold_cnt==MAX_HOLD, with done[o]=0 and req[o]=1.
- done bits for non-owners are ignored. done with no grant active is ignored.
- grant is always one-hot or zero, never multi-hot. grant_idx always equals the encoded grant.
- Simultaneous done[o] and hold limit: treated as a normal release; timeout=0.
- Request changes on non-owners during BUSY have no effect until the next arbitration.

Test Plan:
- Reset then single request: rst 1 for 2 cycles, then req=8'h04 → one edge later grant=8'h04, grant_idx=2, grant_valid=1; then done=8'h04 → next edge grant=0, grant_valid=0, ptr=3.
- Round-robin fairness: req=8'hFF held, done pulsed for the owner every 2 cycles → grant sequence 0x01, 0x02, 0x04 … 0x80, 0x01 (wrap from 7 to 0), each with grant_idx matching.
- Pointer priority: after owner 5 releases (ptr=6), req=8'h21 → grant=8'h01 (idx 0 wins over idx 5, order 6,7,0,…).
- Hold timeout: MAX_HOLD=4, req=8'h09 held, no done → owner 0 for 4 cycles; timeout=1 for one cycle; grant=8'h08 with no idle gap; owner 0 re-wins only after owner 3 releases.
- Request drop: owner 3 drops req[3] mid-grant with req=8'h88 → next edge grant=8'h80; if req=8'h08 only and it drops → grant=0, grant_valid=0.
- Reset mid-operation: grant=8'h10 active, assert rst for 1 cycle → grant=0, grant_idx=0, ptr=0; with req=8'h11 afterwards → grant=8'h01.
